// File: rtl/einsum_reduce_seq.sv
// LSE reduction sequencer for one einsum_add instance.
// It streams LEN operands into the adder and returns the final sum.
module einsum_reduce_seq #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter logic [WORD_WIDTH-1:0] EMPTY_VALUE = {WORD_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [1:0]            cfg_pe_mode,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  add_enable,
  output logic                  add_bypass,
  output logic [WORD_WIDTH-1:0] add_operand_a,
  output logic [WORD_WIDTH-1:0] add_operand_b,
  output logic [1:0]            add_pe_mode,
  input  logic [WORD_WIDTH-1:0] add_sum,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 first_q, first_d;
  logic                 empty_q, empty_d;
  logic [1:0]           mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      empty_q <= 1'b0;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      empty_q <= empty_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    first_d       = first_q;
    empty_d       = empty_q;
    mode_d        = mode_q;
    in_ready      = 1'b0;
    add_enable    = 1'b0;
    add_bypass    = 1'b0;
    add_operand_a = '0;
    add_operand_b = '0;
    out_valid     = 1'b0;
    out_data      = '0;
    add_pe_mode   = mode_q;
    busy          = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (!abort && start) begin
          rem_d   = len;
          mode_d  = cfg_pe_mode;
          first_d = 1'b1;
          if (len == '0) begin
            empty_d = 1'b1;
            state_d = DONE;
          end else begin
            empty_d = 1'b0;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        in_ready      = 1'b1;
        add_bypass    = first_q;
        add_operand_a = first_q ? in_data : add_sum;
        add_operand_b = in_data;
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          // Adder registers the sum on this edge; next element sees it.
          add_enable = 1'b1;
          first_d    = 1'b0;
          rem_d      = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_data  = empty_q ? EMPTY_VALUE : add_sum;
        if (abort || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_einsum_reduce_seq.sv
// Directed bench for einsum_reduce_seq with a stand-in adder.
// The stand-in combines with a+b; bypass loads operand_a.
module tb_einsum_reduce_seq;

  localparam logic [31:0] EMPTY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic [1:0]  cfg_pe_mode = 2'b00;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        add_enable;
  logic        add_bypass;
  logic [31:0] add_operand_a;
  logic [31:0] add_operand_b;
  logic [1:0]  add_pe_mode;
  logic [31:0] add_sum;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [31:0] run = '0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  einsum_reduce_seq #(
    .WORD_WIDTH(32),
    .CNT_WIDTH(16),
    .EMPTY_VALUE(EMPTY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .len(len),
    .cfg_pe_mode(cfg_pe_mode),
    .abort(abort),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .add_enable(add_enable),
    .add_bypass(add_bypass),
    .add_operand_a(add_operand_a),
    .add_operand_b(add_operand_b),
    .add_pe_mode(add_pe_mode),
    .add_sum(add_sum),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) add_sum <= '0;
    else if (add_enable)
      add_sum <= add_bypass ? add_operand_a
                            : add_operand_a + add_operand_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] n, input logic [1:0] m);
    start = 1'b1;
    len = n;
    cfg_pe_mode = m;
    tick();
    start = 1'b0;
    len = 16'd7;
    cfg_pe_mode = ~m;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    in_data = 32'hFFFF_FFFF;
    #1;
    chk("gap_enable", {31'b0, add_enable}, 32'd0);
    chk("gap_ready", {31'b0, in_ready}, 32'd1);
    chk("gap_sum_held", add_sum, run);
    tick();
  endtask

  task automatic send(input logic [31:0] d, input bit first,
                      input bit last);
    logic [31:0] prev;
    prev = run;
    in_valid = 1'b1;
    in_data = d;
    #1;
    chk("enable", {31'b0, add_enable}, 32'd1);
    chk("bypass", {31'b0, add_bypass}, {31'b0, first});
    chk("op_a", add_operand_a, first ? d : prev);
    chk("op_b", add_operand_b, d);
    run = first ? d : prev + d;
    if (last) sb.push_back(run);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic finish_job();
    logic [31:0] e;
    chk("out_valid", {31'b0, out_valid}, 32'd1);
    chk("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 32'hx;
    chk("out_data", out_data, e);
    chk("done_enable", {31'b0, add_enable}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_enable", {31'b0, add_enable}, 32'd0);
    chk("rst_bypass", {31'b0, add_bypass}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_op_a", add_operand_a, 32'd0);
    chk("rst_op_b", add_operand_b, 32'd0);
    chk("rst_mode", {30'b0, add_pe_mode}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // len=1 with one idle cycle before the element
    start_job(16'd1, 2'd1);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_mode", {30'b0, add_pe_mode}, 32'd1);
    gap();
    send(32'h0001_2345, 1'b1, 1'b1);
    chk("t1_passthru", out_data, 32'h0001_2345);
    finish_job();

    // len=4 back to back
    start_job(16'd4, 2'd2);
    send(32'h0000_0011, 1'b1, 1'b0);
    chk("t2_mode", {30'b0, add_pe_mode}, 32'd2);
    chk("t2_sum1", add_sum, 32'h0000_0011);
    send(32'h0000_0220, 1'b0, 1'b0);
    send(32'h0000_3300, 1'b0, 1'b0);
    chk("t2_not_done", {31'b0, out_valid}, 32'd0);
    send(32'h0004_0000, 1'b0, 1'b1);
    finish_job();

    // len=3 with in_valid 1,0,0,1,0,1
    start_job(16'd3, 2'd3);
    send(32'h0000_0011, 1'b1, 1'b0);
    gap();
    gap();
    send(32'h0000_0220, 1'b0, 1'b0);
    gap();
    send(32'h0000_3300, 1'b0, 1'b1);
    chk("t3_sum", out_data, 32'h0000_3531);
    finish_job();

    // len=0 with out_ready held low
    start_job(16'd0, 2'd0);
    sb.push_back(EMPTY);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_hold_data", out_data, EMPTY);
      chk("t4_enable", {31'b0, add_enable}, 32'd0);
      tick();
    end
    finish_job();

    // second start during ACCUM is ignored
    start_job(16'd2, 2'd1);
    start = 1'b1;
    len = 16'd7;
    cfg_pe_mode = 2'd3;
    gap();
    start = 1'b0;
    chk("t5_mode_kept", {30'b0, add_pe_mode}, 32'd1);
    send(32'h0000_1000, 1'b1, 1'b0);
    send(32'h0000_0234, 1'b0, 1'b1);
    finish_job();

    // abort after 2 of 5
    start_job(16'd5, 2'd2);
    send(32'h0000_0001, 1'b1, 1'b0);
    send(32'h0000_0002, 1'b0, 1'b0);
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0000_0003;
    #1;
    chk("t6_abort_en", {31'b0, add_enable}, 32'd0);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_out", {31'b0, out_valid}, 32'd0);
      tick();
    end

    // async reset mid-ACCUM
    start_job(16'd3, 2'd1);
    send(32'h0000_0050, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data = 32'h0000_0060;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_ready", {31'b0, in_ready}, 32'd0);
    chk("t7_enable", {31'b0, add_enable}, 32'd0);
    chk("t7_busy", {31'b0, busy}, 32'd0);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    start_job(16'd2, 2'd0);
    send(32'h0000_0700, 1'b1, 1'b0);
    send(32'h0000_0077, 1'b0, 1'b1);
    finish_job();

    chk("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/einsum_reduce_seq.md
Name: einsum_reduce_seq

Overview:
Sequencer that drives one einsum_add instance to perform a log-domain (LSE) reduction over a stream of LEN operands. It accepts elements over a valid/ready input stream and feeds the adder one element per cycle. The first element loads through the adder bypass; every later element is LSE-added to the adder's registered sum. It presents the final sum on a valid/ready output. It sits between the operand fetch/stream logic and the einsum_add datapath, and owns that adder's enable, bypass, operand and mode pins.

Parameters:
WORD_WIDTH, 32, operand/sum width; must match the connected einsum_add.
CNT_WIDTH, 16, width of the element-count field.
EMPTY_VALUE, 32'h0000_0000, result reported for a zero-length reduction.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin reduction; sampled only in IDLE
len  in  CNT_WIDTH  number of elements; sampled with start
cfg_pe_mode  in  2  PE mode for the job; sampled with start
abort  in  1  drop current job, return to IDLE, no output
in_valid  in  1  input element valid
in_data  in  WORD_WIDTH  input element (log domain)
in_ready  out  1  element accepted when in_valid && in_ready
add_enable  out  1  to einsum_add.enable
add_bypass  out  1  to einsum_add.bypass
add_operand_a  out  WORD_WIDTH  to einsum_add.operand_a
add_operand_b  out  WORD_WIDTH  to einsum_add.operand_b
add_pe_mode  out  2  to einsum_add.pe_mode
add_sum  in  WORD_WIDTH  from einsum_add.sum_out
out_valid  out  1  result valid
out_data  out  WORD_WIDTH  reduction result
out_ready  in  1  result consumed when out_valid && out_ready
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - State = IDLE; remaining count = 0; first flag = 0; empty flag = 0; latched pe_mode = 0.
  - Outputs: in_ready 0, add_enable 0, add_bypass 0, out_valid 0, busy 0, add_operand_a/b 0, add_pe_mode 0.
- States: IDLE, ACCUM, DONE.
- IDLE, start=1:
  - Latch len into remaining, latch cfg_pe_mode, set first=1.
  - If len==0: set empty=1 and go to DONE.
  - Otherwise: set empty=0 and go to ACCUM.
- ACCUM:
  - in_ready = 1.
  - Accept condition: acc = in_valid && in_ready.
  - add_enable = acc, combinational, same cycle.
  - add_bypass = first.
  - add_operand_a = first ? in_data : add_sum.
  - add_operand_b = in_data.
  - add_pe_mode = latched mode in all states.
  - On acc: first <= 0 and remaining <= remaining-1.
  - If remaining==1 on acc: go to DONE.
  - No acc (in_valid low): hold everything; the adder holds its sum because enable is low.
- Timing:
  - Throughput is 1 element/cycle.
  - The adder sum updates on the edge after acc.
  - The next element uses that updated add_sum the next cycle, so no bubble is needed.
- DONE:
  - out_valid = 1.
  - out_data = empty ? EMPTY_VALUE : add_sum.
  - Latency: last-element accept edge to out_valid is 1 cycle.
  - out_data is stable while waiting (add_enable is 0 in DONE/IDLE).
  - On out_valid && out_ready: go to IDLE.
- start outside IDLE is ignored; len/cfg_pe_mode are not re-sampled.
- abort:
  - In ACCUM or DONE: go to IDLE next edge, with no result handshake.
  - abort has priority over acc; add_enable is forced to 0 in that cycle.
  - In IDLE, abort has priority over start.
- add_operand_a/b are driven 0 when not in ACCUM.
- remaining is only decremented on acc and cannot underflow (DONE is entered at 1).

Test Plan:
- len=1, in_data=32'h0001_2345 given 1 cycle after start -> add_bypass=1 with add_enable for 1 cycle; out_valid the next cycle with out_data=32'h0001_2345 (adder bypass pass-through).
- len=4, in_valid continuous -> add_enable high 4 consecutive cycles; add_bypass only on the 1st; operand_a on elements 2-4 equals add_sum of the previous cycle; out_valid exactly 1 cycle after the 4th accept; out_data equals the model LSE of the 4 values.
- len=3, in_valid toggling 1,0,0,1,0,1 -> exactly 3 add_enable pulses aligned to in_valid; add_sum held during gaps; result matches the back-to-back case.
- len=0 -> DONE on the next edge; out_data=EMPTY_VALUE; add_enable never asserted; with out_ready held low 5 cycles, out_valid stays 1; returns to IDLE on the ready cycle.
- Second start during ACCUM (len=2, new len=7) ignored -> job completes after 2 elements; abort asserted after 2 of 5 elements -> IDLE next cycle, out_valid never asserted, busy drops.
- rst_n pulsed low mid-ACCUM (asynchronously, between edges) -> in_ready, add_enable and busy go 0 immediately; a new start with len=2 then completes normally.
